alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered successor to the combinational 8-bit ALU. Operands A and B and a MIPS-style function opcode are loaded over one shared data bus using three load strobes, as driven by board switches and debounced buttons. A small FSM runs the operation and registers the result and flags. Sits between the input-debounce logic and the LED/display outputs of the lab top level.

## Interface
- NB_DATA, 8, operand/result width (≥ NB_OP, ≥ 4)
- NB_OP, 6, opcode width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- data_in  in  NB_DATA  shared load bus
- load_a  in  1  one-cycle strobe: A ← data_in
- load_b  in  1  one-cycle strobe: B ← data_in
- load_op  in  1  one-cycle strobe: OP ← data_in[NB_OP-1:0]
- out  out  NB_DATA  registered result
- carry  out  1  registered carry (ADD/SUB only, else 0)
- overflow  out  1  registered signed overflow (ADD/SUB only, else 0)
- zero  out  1  registered, out == 0
- op_err  out  1  registered, last executed opcode unsupported
- valid  out  1  out and flags correspond to the current A/B/OP
- loaded  out  3  {op, b, a} loaded mask

## Operation
- Opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRL 000010, SRA 000011.
- ADD: {carry,out} = A + B. SUB: {carry,out} = A + ~B + 1, so carry = 1 iff A ≥ B unsigned. overflow = signed overflow of that sum.
- SRL/SRA: shift A right by unsigned B. For B ≥ NB_DATA, SRL gives 0 and SRA gives all bits = A[MSB].
- Unsupported opcode: out = 0, carry = overflow = 0, zero = 1, op_err = 1.
- Strobes are independent. Simultaneous strobes each capture the same data_in on the same edge.
- FSM states:
  - COLLECT (reset state): each strobe writes its register and sets its loaded bit. When the mask is 111 after the edge, go to EXEC.
  - EXEC: on the next edge, register out/flags from current A/B/OP and set valid = 1, then go to DONE. If a strobe arrives on that edge, the result is still registered from the pre-update values, but valid stays 0 and the state stays EXEC (recompute).
  - DONE: holds the result with valid = 1. Any strobe updates its register, clears valid at that edge, and goes to EXEC. The loaded mask stays 111.
- Reset at any time (including in EXEC): out = 0, carry = overflow = op_err = 0, zero = 1, valid = 0, loaded = 000, A = B = OP = 0, state COLLECT.

## Timing
- A strobe is sampled on the rising edge at edge k.
- If that edge completes the mask (or happens in DONE), the FSM is in EXEC after k. The result and valid = 1 appear after edge k+1.
- Latency: final strobe to valid is 2 edges.
- valid falls on the same edge that accepts any strobe in DONE or EXEC.
- Re-strobing an already-loaded operand in COLLECT overwrites it with no other effect.
- Strobes held high for several cycles reload on every edge. The debounce upstream guarantees single-cycle pulses.
- Outputs change only on clk edges or reset assertion. There is no combinational path from inputs to outputs.

## Test plan
- Reset, then load A=0x7F, B=0x01, OP=0x20 on separate cycles → 2 edges after load_op: out=0x80, carry=0, overflow=1, zero=0, valid=1.
- In DONE, load_b=0x02 then load_op=0x22 (SUB), with A=0x01 → valid drops on each strobe. Final out=0xFF, carry=0, overflow=0, valid=1.
- A=0x01, B=0x02, OP=0x24 (AND) → out=0x00, zero=1. Change OP to 0x25 (OR) → out=0x03, zero=0.
- A=0x80, B=0x02: SRA → 0xE0, SRL → 0x20. With B=0x09: SRA → 0xFF, SRL → 0x00.
- Load only A and B, wait 10 cycles → valid=0, loaded=011. All three strobes together with data_in=0x24 → A=B=0x24, OP=AND, out=0x24.
- OP=0x3F → out=0x00, op_err=1, zero=1. Assert reset during EXEC → all outputs at reset values, loaded=000, and a full reload is required before valid returns.

Source files
------------

// File: rtl/alu_seq.sv
`timescale 1ns/1ps
// alu_seq: registered ALU with operands and opcode loaded over one shared bus.
// Three strobes load A, B and OP. A three-state FSM (COLLECT/EXEC/DONE) decides
// when to register the result and flags, and when the result is valid.
module alu_seq #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NB_DATA-1:0] data_in,
    input  logic               load_a,
    input  logic               load_b,
    input  logic               load_op,
    output logic [NB_DATA-1:0] out,
    output logic               carry,
    output logic               overflow,
    output logic               zero,
    output logic               op_err,
    output logic               valid,
    output logic [2:0]         loaded
);

    // MIPS function codes; wider opcode fields are zero-extended.
    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);

    // Shift amounts at or above the data width saturate (0 or sign fill).
    localparam logic [NB_DATA-1:0] SHIFT_LIMIT = NB_DATA'(NB_DATA);
    localparam int                 MSB         = NB_DATA - 1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EXEC    = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               valid_next;
    logic               exec_fire;

    logic [NB_DATA-1:0] a;
    logic [NB_DATA-1:0] b;
    logic [NB_OP-1:0]   op;

    logic [2:0]         strobe;
    logic               any_strobe;

    logic [NB_DATA:0]   add_sum;
    logic [NB_DATA:0]   sub_sum;
    logic [NB_DATA-1:0] alu_res;
    logic               alu_carry;
    logic               alu_ovf;
    logic               alu_err;

    assign strobe     = {load_op, load_b, load_a};
    assign any_strobe = |strobe;

    // SUB is A + ~B + 1, so its carry-out is the "no borrow" flag (A >= B).
    assign add_sum = {1'b0, a} + {1'b0, b};
    assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{NB_DATA{1'b0}}, 1'b1};

    // Operand/opcode registers: each strobe independently captures data_in.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, which is what lets EXEC compute from the old
    // operands on the same edge a strobe overwrites them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a  <= '0;
            b  <= '0;
            op <= '0;
        end else begin
            if (load_a)  a  <= data_in;
            if (load_b)  b  <= data_in;
            if (load_op) op <= data_in[NB_OP-1:0];
        end
    end

    // Loaded mask {op, b, a}: bits set on strobe and only clear on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loaded <= 3'b000;
        end else begin
            loaded <= loaded | strobe;
        end
    end

    // Combinational ALU over the currently held A/B/OP.
    // NOTE: every output of an always_comb gets a default before the case, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res   = add_sum[NB_DATA-1:0];
                alu_carry = add_sum[NB_DATA];
                alu_ovf   = (a[MSB] == b[MSB]) && (add_sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_res   = sub_sum[NB_DATA-1:0];
                alu_carry = sub_sum[NB_DATA];
                alu_ovf   = (a[MSB] != b[MSB]) && (sub_sum[MSB] != a[MSB]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOR: alu_res = ~(a | b);
            OP_SRL: begin
                if (b >= SHIFT_LIMIT) alu_res = '0;
                else                  alu_res = a >> b;
            end
            OP_SRA: begin
                if (b >= SHIFT_LIMIT) alu_res = {NB_DATA{a[MSB]}};
                else                  alu_res = $unsigned($signed(a) >>> b);
            end
            default: alu_err = 1'b1;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= COLLECT;
        else       state <= state_next;
    end

    // Next state, next valid, and whether this edge registers a result.
    always_comb begin
        state_next = state;
        valid_next = valid;
        exec_fire  = 1'b0;
        case (state)
            COLLECT: begin
                valid_next = 1'b0;
                if ((loaded | strobe) == 3'b111) state_next = EXEC;
            end
            EXEC: begin
                // The result is registered either way; a strobe on this edge
                // makes it stale, so stay here and recompute next edge.
                exec_fire = 1'b1;
                if (any_strobe) begin
                    valid_next = 1'b0;
                end else begin
                    valid_next = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (any_strobe) begin
                    valid_next = 1'b0;
                    state_next = EXEC;
                end
            end
            default: begin
                valid_next = 1'b0;
                state_next = COLLECT;
            end
        endcase
    end

    // Result, flags and valid registers; result updates only in EXEC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b1;
            op_err   <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= valid_next;
            if (exec_fire) begin
                out      <= alu_res;
                carry    <= alu_carry;
                overflow <= alu_ovf;
                zero     <= (alu_res == '0);
                op_err   <= alu_err;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
// tb_alu_seq: directed checks of alu_seq with hand-computed expected values.
module tb_alu_seq;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       load_a;
    logic       load_b;
    logic       load_op;
    logic [7:0] out;
    logic       carry;
    logic       overflow;
    logic       zero;
    logic       op_err;
    logic       valid;
    logic [2:0] loaded;

    int passed = 0;
    int total  = 0;

    alu_seq #(.NB_DATA(8), .NB_OP(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .load_a   (load_a),
        .load_b   (load_b),
        .load_op  (load_op),
        .out      (out),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero),
        .op_err   (op_err),
        .valid    (valid),
        .loaded   (loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic expect_all(input string tag, input logic [7:0] e_out, input logic e_c,
                              input logic e_ov, input logic e_z, input logic e_err,
                              input logic e_valid, input logic [2:0] e_ld);
        check({tag, ".out"},      out,      e_out);
        check({tag, ".carry"},    carry,    e_c);
        check({tag, ".overflow"}, overflow, e_ov);
        check({tag, ".zero"},     zero,     e_z);
        check({tag, ".op_err"},   op_err,   e_err);
        check({tag, ".valid"},    valid,    e_valid);
        check({tag, ".loaded"},   loaded,   e_ld);
    endtask

    // Called at a negedge: drives strobes over the next rising edge, returns at
    // the following negedge with strobes cleared.
    task automatic pulse(input logic la, input logic lb, input logic lo, input logic [7:0] d);
        data_in = d;
        load_a  = la;
        load_b  = lb;
        load_op = lo;
        @(negedge clk);
        load_a  = 1'b0;
        load_b  = 1'b0;
        load_op = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset   = 1'b1;
        data_in = 8'h00;
        load_a  = 1'b0;
        load_b  = 1'b0;
        load_op = 1'b0;
        tick(2);
        expect_all("reset", 8'h00, 0, 0, 1, 0, 0, 3'b000);
        reset = 1'b0;

        // ADD 0x7F + 0x01: signed overflow, no carry.
        pulse(1, 0, 0, 8'h7F);
        check("ld_a.loaded", loaded, 3'b001);
        pulse(0, 1, 0, 8'h01);
        check("ld_b.loaded", loaded, 3'b011);
        pulse(0, 0, 1, 8'h20);
        check("ld_op.valid", valid, 1'b0);
        check("ld_op.loaded", loaded, 3'b111);
        tick(1);
        expect_all("add_ovf", 8'h80, 0, 1, 0, 0, 1, 3'b111);

        // DONE: each strobe drops valid and the held result is unchanged.
        pulse(1, 0, 0, 8'h01);
        check("done_a.valid", valid, 1'b0);
        check("done_a.out_held", out, 8'h80);
        tick(1);
        expect_all("add_1_1", 8'h02, 0, 0, 0, 0, 1, 3'b111);
        pulse(0, 1, 0, 8'h02);
        check("done_b.valid", valid, 1'b0);
        tick(1);
        check("add_1_2.out", out, 8'h03);
        pulse(0, 0, 1, 8'h22);
        check("done_op.valid", valid, 1'b0);
        tick(1);
        expect_all("sub_1_2", 8'hFF, 0, 0, 0, 0, 1, 3'b111);

        // Logic ops.
        pulse(0, 0, 1, 8'h24);
        tick(1);
        expect_all("and", 8'h00, 0, 0, 1, 0, 1, 3'b111);
        pulse(0, 0, 1, 8'h25);
        tick(1);
        expect_all("or", 8'h03, 0, 0, 0, 0, 1, 3'b111);
        pulse(0, 0, 1, 8'h26);
        tick(1);
        check("xor.out", out, 8'h03);
        pulse(0, 0, 1, 8'h27);
        tick(1);
        check("nor.out", out, 8'hFC);

        // Back-to-back strobes: second lands in EXEC, result from old OP (NOR
        // of 0x80,0x02 = 0x7D) with valid still low, then recomputed as SRA.
        pulse(1, 0, 0, 8'h80);
        pulse(0, 0, 1, 8'h03);
        check("exec_strobe.valid", valid, 1'b0);
        check("exec_strobe.out", out, 8'h7D);
        tick(1);
        expect_all("sra_2", 8'hE0, 0, 0, 0, 0, 1, 3'b111);
        pulse(0, 0, 1, 8'h02);
        tick(1);
        check("srl_2.out", out, 8'h20);
        pulse(0, 1, 0, 8'h09);
        tick(1);
        expect_all("srl_9", 8'h00, 0, 0, 1, 0, 1, 3'b111);
        pulse(0, 0, 1, 8'h03);
        tick(1);
        check("sra_9.out", out, 8'hFF);
        pulse(0, 1, 0, 8'h08);
        tick(1);
        check("sra_8.out", out, 8'hFF);
        pulse(0, 0, 1, 8'h02);
        tick(1);
        check("srl_8.out", out, 8'h00);
        pulse(0, 1, 0, 8'h07);
        tick(1);
        check("srl_7.out", out, 8'h01);

        // Carry cases.
        pulse(1, 0, 0, 8'hFF);
        pulse(0, 1, 0, 8'h01);
        pulse(0, 0, 1, 8'h20);
        tick(1);
        expect_all("add_carry", 8'h00, 1, 0, 1, 0, 1, 3'b111);
        pulse(1, 0, 0, 8'h80);
        pulse(0, 0, 1, 8'h22);
        tick(1);
        expect_all("sub_80_01", 8'h7F, 1, 1, 0, 0, 1, 3'b111);

        // Partial load after reset never becomes valid.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        pulse(1, 0, 0, 8'h55);
        pulse(0, 1, 0, 8'h66);
        tick(10);
        check("partial.valid", valid, 1'b0);
        check("partial.loaded", loaded, 3'b011);
        pulse(1, 1, 1, 8'h24);
        check("all3.loaded", loaded, 3'b111);
        check("all3.valid", valid, 1'b0);
        tick(1);
        expect_all("all3", 8'h24, 0, 0, 0, 0, 1, 3'b111);

        // Unsupported opcode.
        pulse(0, 0, 1, 8'h3F);
        tick(1);
        expect_all("bad_op", 8'h00, 0, 0, 1, 1, 1, 3'b111);

        // Reset while in EXEC clears everything asynchronously.
        pulse(0, 0, 1, 8'h20);
        reset = 1'b1;
        #1;
        expect_all("rst_exec", 8'h00, 0, 0, 1, 0, 0, 3'b000);
        tick(1);
        reset = 1'b0;
        pulse(1, 0, 0, 8'h10);
        pulse(0, 1, 0, 8'h20);
        tick(3);
        check("reload_ab.valid", valid, 1'b0);
        check("reload_ab.loaded", loaded, 3'b011);
        pulse(0, 0, 1, 8'h20);
        tick(1);
        expect_all("reload", 8'h30, 0, 0, 0, 0, 1, 3'b111);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
